// File: rtl/shift_piso_tx.sv
// rtl/shift_piso_tx.sv - double-buffered parallel-in serial-out transmitter, MSB first
// All state advances on the falling edge of CLK; CLR clears asynchronously.
module shift_piso_tx #(
  parameter int WIDTH = 4
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic [WIDTH-1:0] Din,
  input  logic             Ld_Valid,
  output logic             Ld_Ready,
  output logic             Sout,
  output logic             Sr_En_o,
  output logic             Busy,
  output logic             Done
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             hold_full_q, hold_full_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             accept;

  assign accept = Ld_Valid & ~hold_full_q;

  always_ff @(negedge CLK or posedge CLR) begin
    if (CLR) begin
      state_q     <= IDLE;
      sh_q        <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      cnt_q       <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sh_q        <= sh_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      cnt_q       <= cnt_d;
      done_q      <= done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    sh_d        = sh_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    cnt_d       = cnt_q;
    done_d      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (hold_full_q) begin
          sh_d        = hold_q;
          hold_full_d = 1'b0;
          cnt_d       = CNT_LAST;
          state_d     = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt_q != '0) begin
          sh_d  = {sh_q[WIDTH-2:0], 1'b0};
          cnt_d = cnt_q - 1'b1;
        end else if (hold_full_q) begin
          // Reload on the last bit so the next word follows with no gap.
          sh_d        = hold_q;
          hold_full_d = 1'b0;
          cnt_d       = CNT_LAST;
        end else begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Accept only happens with the hold buffer empty, so it never races a transfer.
    if (accept) begin
      hold_d      = Din;
      hold_full_d = 1'b1;
    end
  end

  assign Ld_Ready = ~hold_full_q;
  assign Sr_En_o  = (state_q == SHIFT);
  assign Sout     = (state_q == SHIFT) & sh_q[WIDTH-1];
  assign Busy     = (state_q == SHIFT) | hold_full_q;
  assign Done     = done_q;

endmodule

// File: tb/tb_shift_piso_tx.sv
// tb/tb_shift_piso_tx.sv - directed self-checking bench for shift_piso_tx (WIDTH=4)
module tb_shift_piso_tx;

  logic       CLK;
  logic       CLR;
  logic [3:0] Din;
  logic       Ld_Valid;
  logic       Ld_Ready;
  logic       Sout;
  logic       Sr_En_o;
  logic       Busy;
  logic       Done;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] rx_q;
  int          rx_n;
  int          done_cnt;
  int          en_rises;
  int          acc_cnt;
  logic        en_prev;
  logic [3:0]  sw;

  shift_piso_tx #(.WIDTH(4)) dut (
    .CLK      (CLK),
    .CLR      (CLR),
    .Din      (Din),
    .Ld_Valid (Ld_Valid),
    .Ld_Ready (Ld_Ready),
    .Sout     (Sout),
    .Sr_En_o  (Sr_En_o),
    .Busy     (Busy),
    .Done     (Done)
  );

  initial CLK = 1'b1;
  always #5 CLK = ~CLK;

  // Receiver model: bits are stable mid-period, sample them on the rising edge.
  always @(posedge CLK) begin
    if (Sr_En_o) begin
      rx_q = {rx_q[30:0], Sout};
      rx_n++;
    end
    if (Sr_En_o && !en_prev) en_rises++;
    en_prev = Sr_En_o;
    if (Done) done_cnt++;
  end

  always @(negedge CLK) begin
    if (!CLR && Ld_Valid && Ld_Ready) acc_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_logs;
    rx_q     = '0;
    rx_n     = 0;
    done_cnt = 0;
    en_rises = 0;
    acc_cnt  = 0;
  endtask

  task automatic wait_idle(input string tag);
    int k;
    k = 0;
    while (Busy && k < 50) begin
      step();
      k++;
    end
    check({tag, "_idle"}, 32'(Busy), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    CLR      = 1'b1;
    Din      = '0;
    Ld_Valid = 1'b0;
    en_prev  = 1'b0;
    clear_logs();
    step();
    step();
    check("rst_sout",  32'(Sout),     32'd0);
    check("rst_sren",  32'(Sr_En_o),  32'd0);
    check("rst_busy",  32'(Busy),     32'd0);
    check("rst_done",  32'(Done),     32'd0);
    check("rst_ready", 32'(Ld_Ready), 32'd1);
    CLR = 1'b0;
    step();
    check("post_rst_ready", 32'(Ld_Ready), 32'd1);

    // Single word 1011: accepted at edge N, bits after N+1..N+4, Done after N+5.
    clear_logs();
    sw       = 4'b1011;
    Din      = sw;
    Ld_Valid = 1'b1;
    step();
    Ld_Valid = 1'b0;
    Din      = '0;
    check("single_accept", 32'({Ld_Ready, Busy, Sr_En_o}), 32'b010);
    for (int i = 0; i < 4; i++) begin
      step();
      check("single_bit",    32'(Sout),              32'(sw[3-i]));
      check("single_en_dn",  32'({Sr_En_o, Done}),   32'b10);
    end
    step();
    check("single_done",   32'({Sr_En_o, Done, Busy}), 32'b010);
    step();
    check("single_done_drop", 32'(Done), 32'd0);
    check("single_rx",     rx_q[3:0] , 32'hB);
    check("single_rx_n",   32'(rx_n),     32'd4);
    check("single_dcnt",   32'(done_cnt), 32'd1);

    // Back-to-back A then 5, second offered while the first shifts.
    clear_logs();
    Din      = 4'hA;
    Ld_Valid = 1'b1;
    step();
    Ld_Valid = 1'b0;
    step();
    Din      = 4'h5;
    Ld_Valid = 1'b1;
    step();
    Ld_Valid = 1'b0;
    wait_idle("b2b");
    step();
    check("b2b_bits",   rx_q[7:0],        32'hA5);
    check("b2b_rx_n",   32'(rx_n),        32'd8);
    check("b2b_gapless",32'(en_rises),    32'd1);
    check("b2b_dcnt",   32'(done_cnt),    32'd1);
    check("b2b_acc",    32'(acc_cnt),     32'd2);

    // Back-pressure: 9 shifting, 6 in hold, F offered for 3 blocked cycles.
    clear_logs();
    Din      = 4'h9;
    Ld_Valid = 1'b1;
    step();
    Ld_Valid = 1'b0;
    step();
    Din      = 4'h6;
    Ld_Valid = 1'b1;
    step();
    Din      = 4'hF;
    for (int i = 0; i < 3; i++) begin
      check("bp_blocked", 32'(Ld_Ready), 32'd0);
      step();
    end
    check("bp_ready_rise", 32'(Ld_Ready), 32'd1);
    step();
    Ld_Valid = 1'b0;
    check("bp_taken", 32'(Ld_Ready), 32'd0);
    wait_idle("bp");
    step();
    check("bp_bits",    rx_q[11:0],     32'h96F);
    check("bp_rx_n",    32'(rx_n),      32'd12);
    check("bp_acc",     32'(acc_cnt),   32'd3);
    check("bp_gapless", 32'(en_rises),  32'd1);
    check("bp_dcnt",    32'(done_cnt),  32'd1);

    // Reset mid-operation: two bits of C out, 3 sitting in hold.
    clear_logs();
    Din      = 4'hC;
    Ld_Valid = 1'b1;
    step();
    Ld_Valid = 1'b0;
    step();
    Din      = 4'h3;
    Ld_Valid = 1'b1;
    step();
    Ld_Valid = 1'b0;
    check("mid_pre_busy", 32'({Busy, Sout, Ld_Ready}), 32'b110);
    #2;
    CLR = 1'b1;
    #1;
    check("mid_sout",  32'(Sout),     32'd0);
    check("mid_sren",  32'(Sr_En_o),  32'd0);
    check("mid_busy",  32'(Busy),     32'd0);
    check("mid_done",  32'(Done),     32'd0);
    check("mid_ready", 32'(Ld_Ready), 32'd1);
    step();
    CLR = 1'b0;
    clear_logs();
    for (int i = 0; i < 6; i++) step();
    check("mid_no_bits", 32'(rx_n),     32'd0);
    check("mid_no_done", 32'(done_cnt), 32'd0);
    check("mid_idle",    32'(Busy),     32'd0);
    Din      = 4'h5;
    Ld_Valid = 1'b1;
    step();
    Ld_Valid = 1'b0;
    wait_idle("after_rst");
    step();
    check("after_rst_bits", rx_q[3:0],       32'h5);
    check("after_rst_n",    32'(rx_n),       32'd4);
    check("after_rst_dcnt", 32'(done_cnt),   32'd1);

    // Idle hygiene.
    for (int i = 0; i < 10; i++) begin
      step();
      check("idle_outs", 32'({Sout, Sr_En_o, Done, Busy}), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
